// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and LED pattern helpers for the egg-timer LED stage
package led_pkg;

    localparam int LED_DEFAULT_SIZE      = 4;
    localparam int LED_DEFAULT_BLINK_DIV = 1;

    // Widest LED bank the helpers can describe; callers keep the low SIZE bits.
    localparam int LED_MAX_SIZE = 64;

    // All-lit mask for a bank of the given width.
    function automatic logic [LED_MAX_SIZE-1:0] led_all_on(input int size);
        logic [LED_MAX_SIZE-1:0] mask;
        mask = '0;
        for (int i = 0; i < LED_MAX_SIZE; i++) begin
            if (i < size) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    // All-dark mask for a bank of the given width.
    function automatic logic [LED_MAX_SIZE-1:0] led_all_off(input int size);
        logic [LED_MAX_SIZE-1:0] mask;
        mask = '0;
        if (size < 0) begin
            mask = '0;
        end
        return mask;
    endfunction

endpackage

// File: rtl/led_driver_blink_divider.sv
// rtl/led_driver_blink_divider.sv - blink half-period divider, tick on wrap
module blink_divider #(
    parameter int BLINK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && !clear && (cnt_q == CNT_LAST);

    // Count 0..BLINK_DIV-1 while enabled; clear holds the phase at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Divider state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_driver.sv
// rtl/led_driver.sv - LED output stage: count passthrough, sticky alarm blink (chase with LED_DRIVER_CHASE_EN)
module led_driver
    import led_pkg::*;
#(
    parameter int SIZE      = LED_DEFAULT_SIZE,
    parameter int BLINK_DIV = LED_DEFAULT_BLINK_DIV
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alarm,
    input  logic [SIZE-1:0] count,
    output logic [SIZE-1:0] led
);

`ifdef LED_DRIVER_CHASE_EN
    // Chase keeps the one-hot LED image itself as the pattern.
    localparam int PAT_W = SIZE;
`else
    // Blink only needs the on/off phase bit.
    localparam int PAT_W = 1;
`endif

    logic            alarm_active_q;
    logic            alarm_active_d;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] pat_d;
    logic [PAT_W-1:0] pat_adv;
    logic [SIZE-1:0] pat_led;
    logic [SIZE-1:0] led_q;
    logic [SIZE-1:0] led_d;
    logic            tick;

    // Divider runs only in alarm mode and sits at zero otherwise, so the
    // capture edge always starts a fresh half-period.
    blink_divider #(
        .BLINK_DIV(BLINK_DIV)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .clear(!alarm_active_q),
        .en   (alarm_active_q),
        .tick (tick)
    );

`ifdef LED_DRIVER_CHASE_EN
    // Rotate left; the shift pair degenerates to identity when SIZE is 1.
    assign pat_adv = (pat_q << 1) | (pat_q >> (SIZE - 1));
    assign pat_led = pat_d;
`else
    localparam logic [LED_MAX_SIZE-1:0] ALL_ON_W  = led_all_on(SIZE);
    localparam logic [LED_MAX_SIZE-1:0] ALL_OFF_W = led_all_off(SIZE);
    localparam logic [SIZE-1:0]         ALL_ON    = ALL_ON_W[SIZE-1:0];
    localparam logic [SIZE-1:0]         ALL_OFF   = ALL_OFF_W[SIZE-1:0];

    assign pat_adv = ~pat_q;
    assign pat_led = pat_d[0] ? ALL_ON : ALL_OFF;
`endif

    // Sticky alarm capture and pattern advance on divider wrap.
    always_comb begin
        alarm_active_d = alarm_active_q;
        pat_d          = pat_q;
        if (!alarm_active_q) begin
            if (alarm) begin
                alarm_active_d = 1'b1;
                pat_d          = PAT_W'(1);
            end
        end else if (tick) begin
            pat_d = pat_adv;
        end
    end

    // Output mux: pattern image in alarm mode, raw count otherwise.
    always_comb begin
        led_d = count;
        if (alarm_active_d) begin
            led_d = pat_led;
        end
    end

    // State and registered LED drive; reset wins over a same-edge alarm.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_active_q <= 1'b0;
            pat_q          <= '0;
            led_q          <= '0;
        end else begin
            alarm_active_q <= alarm_active_d;
            pat_q          <= pat_d;
            led_q          <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_driver.sv
// tb/tb_led_driver.sv - directed self-checking bench for led_driver (SIZE=4, BLINK_DIV=1)
module tb_led_driver;

    logic       clk;
    logic       rst;
    logic       alarm;
    logic [3:0] count;
    logic [3:0] led;

    int vectors;
    int miscompares;

    led_driver #(
        .SIZE     (4),
        .BLINK_DIV(1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .alarm(alarm),
        .count(count),
        .led  (led)
    );

    initial clk = 1'b0;
    always #15 clk = ~clk;

    // Apply one rising edge and compare led 1 time unit later.
    task automatic step(input logic [3:0] exp, input string tag);
        @(posedge clk);
        #1;
        vectors++;
        assert (led === exp) else begin
            miscompares++;
            $error("FAIL %s: led=%b expected %b", tag, led, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        alarm = 1'b1;
        count = 4'd7;

        // Reset dominates a simultaneous alarm.
        step(4'b0000, "reset");
        rst   = 1'b0;
        alarm = 1'b0;
        count = 4'd3;
        step(4'd3, "post_reset_normal");

        // Passthrough across the 15->0 wrap.
        for (int i = 0; i < 18; i++) begin
            count = 4'(i);
            step(4'(i), "count_track");
        end

        // Narrow pulse between edges is ignored.
        #5 alarm = 1'b1;
        #5 alarm = 1'b0;
        count = 4'd6;
        step(4'd6, "narrow_pulse_ignored");
        count = 4'd12;
        step(4'd12, "still_normal");

        // Alarm high for 2 units spanning an edge.
        count = 4'd5;
        @(negedge clk);
        #14 alarm = 1'b1;
        @(posedge clk);
        #1 alarm = 1'b0;
        vectors++;
`ifdef LED_DRIVER_CHASE_EN
        assert (led === 4'b0001) else begin
            miscompares++;
            $error("FAIL capture: led=%b expected %b", led, 4'b0001);
        end
        count = 4'd2;
        step(4'b0010, "chase_1");
        count = 4'd9;
        step(4'b0100, "chase_2");
        alarm = 1'b1;
        step(4'b1000, "chase_realarm_no_restart");
        alarm = 1'b0;
        step(4'b0001, "chase_wrap");
`else
        assert (led === 4'b1111) else begin
            miscompares++;
            $error("FAIL capture: led=%b expected %b", led, 4'b1111);
        end
        count = 4'd2;
        step(4'b0000, "blink_off_1");
        count = 4'd9;
        step(4'b1111, "blink_on_1");
        alarm = 1'b1;
        step(4'b0000, "blink_realarm_no_restart");
        alarm = 1'b0;
        step(4'b1111, "blink_on_2");
`endif

        // Reset mid-alarm returns to dark, then normal mode.
        count = 4'd9;
        rst   = 1'b1;
        step(4'b0000, "reset_mid_alarm");
        rst = 1'b0;
        step(4'b1001, "normal_after_reset");
        count = 4'd10;
        step(4'b1010, "normal_after_reset_2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
